// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the shared register-file write port, with a busy scoreboard.
// Optional same-cycle read bypass of the committing write: REGFILE_WB_BYPASS_EN.
`ifndef XLEN
`define XLEN 32
`endif

module regfile_wb_arbiter #(
  parameter int unsigned INIT_PRIO = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [4:0]        req0_addr,
  input  logic [`XLEN-1:0]  req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [4:0]        req1_addr,
  input  logic [`XLEN-1:0]  req1_data,
  input  logic              sb_set,
  input  logic [4:0]        sb_set_addr,
  output logic [31:0]       sb_busy,
  input  logic [4:0]        rd_addr,
  output logic [`XLEN-1:0]  rd_data,
  output logic [4:0]        rf_read_addr,
  input  logic [`XLEN-1:0]  rf_read_data,
  output logic              rf_write,
  output logic [4:0]        rf_write_addr,
  output logic [`XLEN-1:0]  rf_write_data
);

  localparam int W = `XLEN;

  typedef struct packed {
    logic         vld;
    logic [4:0]   addr;
    logic [W-1:0] data;
  } wb_t;

  wb_t         wb_q;
  wb_t         wb_nxt;
  logic        prio;
  logic        contend;
  logic        gnt0;
  logic        gnt1;
  logic [31:0] sb_q;
  logic [31:0] sb_nxt;

  // prio=0 favours req0 when both are valid
  always_comb begin
    contend = req0_valid && req1_valid;
    gnt0 = rstn && req0_valid && (!req1_valid || !prio);
    gnt1 = rstn && req1_valid && (!req0_valid || prio);
  end

  always_comb begin
    wb_nxt = wb_q;
    wb_nxt.vld = 1'b0;
    unique case (1'b1)
      gnt0: begin
        if (req0_addr != 5'd0) begin
          wb_nxt.vld  = 1'b1;
          wb_nxt.addr = req0_addr;
          wb_nxt.data = req0_data;
        end
      end
      gnt1: begin
        if (req1_addr != 5'd0) begin
          wb_nxt.vld  = 1'b1;
          wb_nxt.addr = req1_addr;
          wb_nxt.data = req1_data;
        end
      end
      default: ;
    endcase
  end

  // set after clear: a newly issued producer outranks the retiring one
  always_comb begin
    sb_nxt = sb_q;
    if (wb_q.vld && wb_q.addr != 5'd0)
      sb_nxt[wb_q.addr] = 1'b0;
    if (sb_set && sb_set_addr != 5'd0)
      sb_nxt[sb_set_addr] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_q <= '0;
      sb_q <= '0;
      prio <= (INIT_PRIO != 0);
    end else begin
      wb_q <= wb_nxt;
      sb_q <= sb_nxt;
      if (contend)
        prio <= ~prio;
    end
  end

  assign req0_ready    = gnt0;
  assign req1_ready    = gnt1;
  assign sb_busy       = sb_q;
  assign rf_write      = wb_q.vld;
  assign rf_write_addr = wb_q.addr;
  assign rf_write_data = wb_q.data;
  assign rf_read_addr  = rd_addr;

`ifdef REGFILE_WB_BYPASS_EN
  always_comb begin
    rd_data = rf_read_data;
    if (wb_q.vld && wb_q.addr == rd_addr && rd_addr != 5'd0)
      rd_data = wb_q.data;
  end
`else
  assign rd_data = rf_read_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter.
// Expected writes are queued at issue; a monitor checks each rf_write.
`ifndef XLEN
`define XLEN 32
`endif

module tb_regfile_wb_arbiter;

  logic              clk = 1'b0;
  logic              rstn;
  logic              req0_valid;
  logic              req0_ready;
  logic [4:0]        req0_addr;
  logic [`XLEN-1:0]  req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [4:0]        req1_addr;
  logic [`XLEN-1:0]  req1_data;
  logic              sb_set;
  logic [4:0]        sb_set_addr;
  logic [31:0]       sb_busy;
  logic [4:0]        rd_addr;
  logic [`XLEN-1:0]  rd_data;
  logic [4:0]        rf_read_addr;
  logic [`XLEN-1:0]  rf_read_data;
  logic              rf_write;
  logic [4:0]        rf_write_addr;
  logic [`XLEN-1:0]  rf_write_data;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [4:0]       a;
    logic [`XLEN-1:0] d;
  } wr_t;

  wr_t exq[$];

  logic [`XLEN-1:0] rf [32];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.INIT_PRIO(0)) dut (
    .clk(clk),
    .rstn(rstn),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_addr(req0_addr),
    .req0_data(req0_data),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_addr(req1_addr),
    .req1_data(req1_data),
    .sb_set(sb_set),
    .sb_set_addr(sb_set_addr),
    .sb_busy(sb_busy),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data),
    .rf_write(rf_write),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data)
  );

  // register file model, reset values all zero
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= '0;
    end else if (rf_write && rf_write_addr != 5'd0) begin
      rf[rf_write_addr] <= rf_write_data;
    end
  end

  assign rf_read_data = (rf_read_addr == 5'd0) ? '0 : rf[rf_read_addr];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rf_write) begin
        if (exq.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexp_write: got addr %0d expected no write",
                   rf_write_addr);
        end else begin
          wr_t e;
          e = exq.pop_front();
          chk("wr_addr", 32'(rf_write_addr), 32'(e.a));
          chk("wr_data", rf_write_data, e.d);
        end
      end
    end
  end

  task automatic cyc(input logic v0,
                     input logic [4:0] a0,
                     input logic [31:0] d0,
                     input logic v1,
                     input logic [4:0] a1,
                     input logic [31:0] d1,
                     input logic s,
                     input logic [4:0] sa,
                     input logic e0,
                     input logic e1);
    wr_t w;
    @(negedge clk);
    req0_valid  = v0;
    req0_addr   = a0;
    req0_data   = d0;
    req1_valid  = v1;
    req1_addr   = a1;
    req1_data   = d1;
    sb_set      = s;
    sb_set_addr = sa;
    if (e0 && a0 != 5'd0) begin
      w.a = a0;
      w.d = d0;
      exq.push_back(w);
    end
    if (e1 && a1 != 5'd0) begin
      w.a = a1;
      w.d = d1;
      exq.push_back(w);
    end
    #1;
    chk("ready0", 32'(req0_ready), 32'(e0));
    chk("ready1", 32'(req1_ready), 32'(e1));
  endtask

  task automatic idle(input logic s, input logic [4:0] sa);
    cyc(0, 0, 0, 0, 0, 0, s, sa, 0, 0);
  endtask

  task automatic rd_chk(input string name,
                        input logic [4:0] a,
                        input logic [31:0] e);
    rd_addr = a;
    #1;
    chk(name, rd_data, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn        = 1'b0;
    req0_valid  = 1'b1;
    req0_addr   = 5'd3;
    req0_data   = 32'h1;
    req1_valid  = 1'b0;
    req1_addr   = '0;
    req1_data   = '0;
    sb_set      = 1'b0;
    sb_set_addr = '0;
    rd_addr     = '0;
    #2;
    chk("rst_ready0", 32'(req0_ready), 32'h0);
    chk("rst_write", 32'(rf_write), 32'h0);
    chk("rst_wr_addr", 32'(rf_write_addr), 32'h0);
    chk("rst_wr_data", rf_write_data, 32'h0);
    chk("rst_busy", sb_busy, 32'h0);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 32; i++)
      rd_chk("rst_read", 5'(i), 32'h0);

    // single write
    cyc(1, 5, 32'h12345678, 0, 0, 0, 0, 0, 1, 0);
    idle(0, 0);
    chk("single_write", 32'(rf_write), 32'h1);
    idle(0, 0);
    chk("single_done", 32'(rf_write), 32'h0);
    rd_chk("single_read", 5, 32'h12345678);

    // x0 discard
    cyc(0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 1);
    idle(0, 0);
    chk("x0_nowrite", 32'(rf_write), 32'h0);
    rd_chk("x0_read", 0, 32'h0);

    // bypass during commit cycle
    cyc(1, 5, 32'hCAFEF00D, 0, 0, 0, 0, 0, 1, 0);
    idle(0, 0);
`ifdef REGFILE_WB_BYPASS_EN
    rd_chk("bypass_read", 5, 32'hCAFEF00D);
`else
    rd_chk("bypass_read", 5, 32'h12345678);
`endif
    idle(0, 0);
    rd_chk("post_commit", 5, 32'hCAFEF00D);

    // contention, grants 0,1,0,1
    cyc(1, 1, 32'hA0, 1, 2, 32'hB0, 0, 0, 1, 0);
    cyc(1, 1, 32'hA1, 1, 2, 32'hB0, 0, 0, 0, 1);
    chk("b2b_1", 32'(rf_write), 32'h1);
    cyc(1, 1, 32'hA1, 1, 2, 32'hB1, 0, 0, 1, 0);
    chk("b2b_2", 32'(rf_write), 32'h1);
    cyc(1, 1, 32'hA2, 1, 2, 32'hB1, 0, 0, 0, 1);
    chk("b2b_3", 32'(rf_write), 32'h1);
    idle(0, 0);
    chk("b2b_4", 32'(rf_write), 32'h1);
    idle(0, 0);
    rd_chk("cont_r1", 1, 32'hA1);
    rd_chk("cont_r2", 2, 32'hB1);

    // scoreboard set / clear
    idle(1, 7);
    idle(0, 0);
    chk("sb_set7", sb_busy, 32'h80);
    cyc(1, 7, 32'h77, 0, 0, 0, 0, 0, 1, 0);
    idle(0, 0);
    chk("sb_pending", sb_busy, 32'h80);
    idle(0, 0);
    chk("sb_clear", sb_busy, 32'h0);
    cyc(1, 7, 32'h78, 0, 0, 0, 0, 0, 1, 0);
    idle(1, 7);
    idle(0, 0);
    chk("sb_set_wins", sb_busy, 32'h80);
    idle(1, 0);
    idle(0, 0);
    chk("sb_set0", sb_busy, 32'h80);

    // reset during a pending write
    cyc(1, 9, 32'h99, 0, 0, 0, 0, 0, 1, 0);
    idle(0, 0);
    chk("mid_pending", 32'(rf_write), 32'h1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_write", 32'(rf_write), 32'h0);
    chk("mid_rst_busy", sb_busy, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    idle(0, 0);
    chk("mid_after", 32'(rf_write), 32'h0);
    chk("queue_empty", 32'(exq.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: req0 (ALU writeback) and req1 (load unit).
- Round-robin grant; registered write stage drives `registers` write_addr/write/write_data.
- Keeps a 32-bit busy scoreboard of destination registers with writes outstanding.
- Owns the read-address/read-data path to the register file.

Parameters:
- INIT_PRIO, 0: requester that wins the first contention after reset (0 or 1).
- XLEN, from `XLEN in defines.v: data width. Not a module parameter.

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has a write pending
- req0_ready  output  1  requester 0 write accepted this cycle
- req0_addr  input  5  requester 0 destination register
- req0_data  input  XLEN  requester 0 write data
- req1_valid  input  1  requester 1 has a write pending
- req1_ready  output  1  requester 1 write accepted this cycle
- req1_addr  input  5  requester 1 destination register
- req1_data  input  XLEN  requester 1 write data
- sb_set  input  1  issue stage marks a destination busy
- sb_set_addr  input  5  register to mark busy
- sb_busy  output  32  busy bit per register; bit 0 is always 0
- rd_addr  input  5  read address from decode
- rd_data  output  XLEN  read data to decode
- rf_read_addr  output  5  to registers.read_addr; equals rd_addr combinationally
- rf_read_data  input  XLEN  from registers.read_data
- rf_write  output  1  to registers.write
- rf_write_addr  output  5  to registers.write_addr
- rf_write_data  output  XLEN  to registers.write_data

Behaviour:
- Reset (asynchronous, rstn low):
  - rf_write=0, rf_write_addr=0, rf_write_data=0.
  - sb_busy=0.
  - Priority pointer = INIT_PRIO.
  - req*_ready=0 while rstn is low.
- Grant (combinational, same cycle):
  - Only one valid requester: it is granted.
  - Both valid: the requester named by the pointer is granted.
  - Neither valid: no grant.
- req*_ready = grant. The write stage never stalls, so ready never depends on downstream state.
- Handshake:
  - Transfer occurs when valid && ready at the rising edge.
  - A requester holds valid/addr/data stable until ready.
- Pointer update: after every granted transfer under contention, the pointer moves to the non-granted requester. A grant without contention leaves the pointer unchanged.
- Write stage, latency 1:
  - A transfer at edge N puts rf_write=1 with the granted addr/data during cycle N+1.
  - The register file commits at edge N+1.
  - rf_write deasserts the cycle after, unless another transfer occurred at edge N+1.
  - Back-to-back transfers give one write per cycle.
- x0 writes:
  - A transfer with addr==0 is accepted (ready=1) but discarded.
  - rf_write stays 0 for it; the pointer still updates.
- Scoreboard:
  - A committing write (rf_write && rf_write_addr!=0) clears sb_busy[rf_write_addr] at the commit edge.
  - sb_set with sb_set_addr!=0 sets the bit at the edge.
  - Set and clear of the same register on the same edge: set wins, because a new producer is in flight.
  - sb_set_addr==0 is ignored.
- Reset mid-operation: the pending write-stage content is dropped (rf_write=0 immediately) and all busy bits clear.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - rd_data = rf_write_data when rf_write && rf_write_addr==rd_addr && rd_addr!=0.
  - Otherwise rd_data = rf_read_data.
  - A read of a register being committed this cycle therefore returns the new value.
- Undefined: rd_data = rf_read_data always. The old value is seen until the cycle after commit.

Test Plan:
- Reset then idle:
  - Stimulus: reset, no requests.
  - Required: rf_write=0, sb_busy=32'h0, reading regs 0..31 through rd_addr returns the register file reset values.
- Single write:
  - Stimulus: req0 valid, addr=5, data=32'h12345678.
  - Required: req0_ready=1 that cycle; next cycle rf_write=1, rf_write_addr=5; afterwards rd_addr=5 reads 32'h12345678.
- Contention:
  - Stimulus: both valid for 4 cycles, INIT_PRIO=0, req0 addr=1, req1 addr=2, distinct data.
  - Required: grants 0,1,0,1; rf_write_addr sequence 1,2,1,2 with one write per cycle.
- x0 discard:
  - Stimulus: req1 valid, addr=0, data=32'hDEADBEEF.
  - Required: req1_ready=1, rf_write stays 0, reg 0 reads 0.
- Scoreboard:
  - sb_set addr=7 -> sb_busy=32'h80.
  - Write to 7 commits -> sb_busy=0.
  - sb_set for 7 on the same edge as its commit -> bit 7 stays 1.
  - sb_set addr=0 -> sb_busy unchanged.
- Bypass and reset:
  - With REGFILE_WB_BYPASS_EN, rd_addr=5 during the commit cycle of 32'hCAFEF00D -> rd_data=32'hCAFEF00D; without the macro -> the old value.
  - Asserting rstn=0 during a pending write -> rf_write=0 at once, sb_busy=0.
